// File: rtl/wb_uart_tx.sv
// wb_uart_tx: Wishbone B3 classic slave feeding a UART 8N1 transmitter.
// CPU writes bytes into a TX FIFO; a bit-serial FSM drains it onto tx.
// A level interrupt flags "all data sent" when enabled.
module wb_uart_tx #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  output logic        tx,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] LVL_ZERO = (AW+1)'(0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // Registers
  state_t         state_r;
  logic [15:0]    div_r;
  logic [15:0]    baud_cnt_r;
  logic [7:0]     shift_r;
  logic [2:0]     bit_idx_r;
  logic           irq_en_r;
  logic           ovf_r;
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [AW:0]    count_r;
  logic [7:0]     fifo_mem_r [FIFO_DEPTH];
  logic           tx_r;
  logic           irq_r;
  logic           ack_r;
  logic [31:0]    dat_r;

  // Combinational helpers
  logic           req_s;
  logic           wr_s;
  logic [1:0]     reg_sel_s;
  logic           push_req_s;
  logic           push_s;
  logic           ovf_set_s;
  logic           ovf_clr_s;
  logic           pop_s;
  logic           full_s;
  logic           empty_s;
  logic           busy_s;
  logic           bit_end_s;
  logic [15:0]    div_load_s;
  logic [31:0]    status_s;
  logic [31:0]    rdata_s;
  logic           unused_s;

  // A request is serviced once: the cycle after ack it is not re-acked.
  assign req_s      = wb_cyc_i & wb_stb_i & ~ack_r;
  assign wr_s       = req_s & wb_we_i;
  assign reg_sel_s  = wb_adr_i[3:2];
  assign full_s     = (count_r == LVL_FULL);
  assign empty_s    = (count_r == LVL_ZERO);
  // Full is judged before any same-cycle pop, so a push while full is lost.
  assign push_req_s = wr_s & (reg_sel_s == 2'd0) & wb_sel_i[0];
  assign push_s     = push_req_s & ~full_s;
  assign ovf_set_s  = push_req_s & full_s;
  assign ovf_clr_s  = wr_s & (reg_sel_s == 2'd1) & wb_dat_i[3];
  assign busy_s     = (state_r != ST_IDLE);
  assign bit_end_s  = (baud_cnt_r == 16'd0);
  // DIV of 0 behaves as 1 so a bit never takes zero cycles.
  assign div_load_s = (div_r == 16'd0) ? 16'd0 : (div_r - 16'd1);
  assign status_s   = {16'd0, 8'(count_r), 4'd0, ovf_r, busy_s, empty_s, full_s};

  assign wb_dat_o = dat_r;
  assign wb_ack_o = ack_r;
  assign wb_err_o = 1'b0;
  assign wb_rty_o = 1'b0;
  assign tx       = tx_r;
  assign irq      = irq_r;

  assign unused_s = ^{wb_cti_i, wb_bte_i, wb_adr_i[1:0], wb_dat_i[31:16], wb_sel_i[3:2]};

  // Pop the FIFO exactly when the FSM loads a new frame.
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      ST_IDLE: pop_s = ~empty_s;
      ST_STOP: pop_s = bit_end_s & ~empty_s;
      default: pop_s = 1'b0;
    endcase
  end

  // Read-data mux for the register map.
  always_comb begin
    rdata_s = 32'd0;
    case (reg_sel_s)
      2'd0:    rdata_s = 32'd0;
      2'd1:    rdata_s = status_s;
      2'd2:    rdata_s = {16'd0, div_r};
      2'd3:    rdata_s = {31'd0, irq_en_r};
      default: rdata_s = 32'd0;
    endcase
  end

  // Bus handshake, registered read data and DIV/CTRL register writes.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      ack_r    <= 1'b0;
      dat_r    <= 32'd0;
      div_r    <= 16'(CLK_DIV);
      irq_en_r <= 1'b0;
    end else begin
      ack_r <= req_s;
      if (req_s & ~wb_we_i) begin
        dat_r <= rdata_s;
      end else begin
        dat_r <= 32'd0;
      end
      if (wr_s & (reg_sel_s == 2'd2)) begin
        if (wb_sel_i[0]) div_r[7:0]  <= wb_dat_i[7:0];
        if (wb_sel_i[1]) div_r[15:8] <= wb_dat_i[15:8];
      end
      if (wr_s & (reg_sel_s == 2'd3) & wb_sel_i[0]) begin
        irq_en_r <= wb_dat_i[0];
      end
    end
  end

  // FIFO storage; contents need no reset because pointers define validity.
  always_ff @(posedge wb_clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= wb_dat_i[7:0];
    end
  end

  // FIFO pointers, fill level and sticky overflow flag.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= LVL_ZERO;
      ovf_r    <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (ovf_clr_s) begin
        ovf_r <= 1'b0;
      end
    end
  end

  // Serialiser FSM: start bit, 8 data bits LSB first, stop bit; baud counter
  // reloads from DIV at every bit boundary so DIV changes land on a boundary.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_r    <= ST_IDLE;
      tx_r       <= 1'b1;
      baud_cnt_r <= 16'd0;
      shift_r    <= 8'd0;
      bit_idx_r  <= 3'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          tx_r <= 1'b1;
          if (!empty_s) begin
            state_r    <= ST_START;
            tx_r       <= 1'b0;
            shift_r    <= fifo_mem_r[rd_ptr_r];
            baud_cnt_r <= div_load_s;
          end
        end
        ST_START: begin
          if (bit_end_s) begin
            state_r    <= ST_DATA;
            tx_r       <= shift_r[0];
            bit_idx_r  <= 3'd0;
            baud_cnt_r <= div_load_s;
          end else begin
            baud_cnt_r <= baud_cnt_r - 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_end_s) begin
            baud_cnt_r <= div_load_s;
            if (bit_idx_r == 3'd7) begin
              state_r <= ST_STOP;
              tx_r    <= 1'b1;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              tx_r      <= shift_r[1];
              shift_r   <= {1'b0, shift_r[7:1]};
            end
          end else begin
            baud_cnt_r <= baud_cnt_r - 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_end_s) begin
            if (!empty_s) begin
              state_r    <= ST_START;
              tx_r       <= 1'b0;
              shift_r    <= fifo_mem_r[rd_ptr_r];
              baud_cnt_r <= div_load_s;
            end else begin
              state_r <= ST_IDLE;
              tx_r    <= 1'b1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r - 16'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          tx_r    <= 1'b1;
        end
      endcase
    end
  end

  // Interrupt: all data drained and line idle, when enabled.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= irq_en_r & empty_s & ~busy_s;
    end
  end

endmodule

// File: tb/tb_wb_uart_tx.sv
// Directed testbench for wb_uart_tx: register table plus frame-level sequences.
module tb_wb_uart_tx;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic [3:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [2:0]  wb_cti_i;
  logic [1:0]  wb_bte_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_rty_o;
  logic        tx;
  logic        irq;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  wb_uart_tx #(.CLK_DIV(434), .FIFO_DEPTH(16)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o), .tx(tx), .irq(irq)
  );

  always #5 wb_clk = ~wb_clk;

  always @(posedge wb_clk) cycle <= cycle + 1;

  typedef struct {
    logic [3:0]  adr;
    logic        we;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk);
    #1;
  endtask

  // Called #1 after an edge; returns #1 after the ack edge.
  task automatic xfer(input logic [3:0] adr, input logic we, input logic [31:0] wdat,
                      input logic [3:0] sel, output logic [31:0] rdat);
    logic got;
    got = 1'b0;
    wb_adr_i = adr; wb_we_i = we; wb_dat_i = wdat; wb_sel_i = sel;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (wb_ack_o) begin
        got = 1'b1;
        break;
      end
    end
    rdat = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL bus_ack_timeout: got no ack expected ack within 8 cycles adr=%0h", adr);
    end
  endtask

  task automatic wr(input logic [3:0] adr, input logic [31:0] d);
    logic [31:0] junk;
    xfer(adr, 1'b1, d, 4'hF, junk);
  endtask

  task automatic rd_check(input string nm, input logic [3:0] adr, input logic [31:0] exp);
    logic [31:0] r;
    xfer(adr, 1'b0, 32'd0, 4'hF, r);
    check(nm, r, exp);
  endtask

  task automatic wait_tx(input logic v, input int lim, input string nm);
    int k;
    k = 0;
    while (tx !== v && k < lim) begin
      step();
      k++;
    end
    if (tx !== v) begin
      checks++;
      errors++;
      $display("FAIL %s: got tx=%b expected tx=%b within %0d cycles", nm, tx, v, lim);
    end
  endtask

  // Expected line level for frame bit slot i (0 start, 1..8 data, 9 stop).
  function automatic logic fbit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    else if (i <= 8) return b[i-1];
    else return 1'b1;
  endfunction

  initial begin
    logic [31:0] r;
    logic [7:0]  ovf_bytes [17];
    logic [7:0]  rx;
    int          a;
    int          nfr;
    int          lows;
    logic        found;
    logic        done;

    vecs[0]  = '{4'h8, 1'b0, 32'h0000_0000, 4'hF, 32'd434};
    vecs[1]  = '{4'h4, 1'b0, 32'h0000_0000, 4'hF, 32'h0000_0002};
    vecs[2]  = '{4'hC, 1'b0, 32'h0000_0000, 4'hF, 32'h0000_0000};
    vecs[3]  = '{4'h0, 1'b0, 32'h0000_0000, 4'hF, 32'h0000_0000};
    vecs[4]  = '{4'h8, 1'b1, 32'h0000_1234, 4'hF, 32'h0000_0000};
    vecs[5]  = '{4'h8, 1'b0, 32'h0000_0000, 4'hF, 32'h0000_1234};
    vecs[6]  = '{4'h8, 1'b1, 32'hFFFF_ABCD, 4'h1, 32'h0000_0000};
    vecs[7]  = '{4'h8, 1'b0, 32'h0000_0000, 4'hF, 32'h0000_12CD};
    vecs[8]  = '{4'h8, 1'b1, 32'h0000_5600, 4'h2, 32'h0000_0000};
    vecs[9]  = '{4'h8, 1'b0, 32'h0000_0000, 4'hF, 32'h0000_56CD};
    vecs[10] = '{4'h9, 1'b0, 32'h0000_0000, 4'hF, 32'h0000_56CD};
    vecs[11] = '{4'hC, 1'b1, 32'hFFFF_FFFF, 4'hE, 32'h0000_0000};
    vecs[12] = '{4'hC, 1'b0, 32'h0000_0000, 4'hF, 32'h0000_0000};
    vecs[13] = '{4'hC, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
    vecs[14] = '{4'hC, 1'b0, 32'h0000_0000, 4'hF, 32'h0000_0001};
    vecs[15] = '{4'hC, 1'b1, 32'h0000_0000, 4'hF, 32'h0000_0000};
    vecs[16] = '{4'hC, 1'b0, 32'h0000_0000, 4'hF, 32'h0000_0000};
    vecs[17] = '{4'h0, 1'b1, 32'h0000_0055, 4'hE, 32'h0000_0000};
    vecs[18] = '{4'h4, 1'b1, 32'h0000_0008, 4'hF, 32'h0000_0000};
    vecs[19] = '{4'h4, 1'b0, 32'h0000_0000, 4'hF, 32'h0000_0002};

    for (int i = 0; i < 17; i++) ovf_bytes[i] = 8'((i * 37) + 5);

    wb_rst = 1'b1; wb_adr_i = 4'h0; wb_dat_i = 32'd0; wb_sel_i = 4'h0; wb_we_i = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_cti_i = 3'd0; wb_bte_i = 2'd0;
    repeat (2) @(posedge wb_clk);
    #1;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    wb_rst = 1'b0;

    // Held strobe: one ack, then a gap cycle.
    wb_adr_i = 4'h8; wb_sel_i = 4'hF; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    step();
    check("ack_pulse_1", {31'd0, wb_ack_o}, 32'd1);
    check("ack_pulse_dat", wb_dat_o, 32'd434);
    step();
    check("ack_pulse_gap", {31'd0, wb_ack_o}, 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    step();

    for (int i = 0; i < 20; i++) begin
      xfer(vecs[i].adr, vecs[i].we, vecs[i].wdat, vecs[i].sel, r);
      if (!vecs[i].we) check($sformatf("vec%0d", i), r, vecs[i].exp);
    end

    // 0x55 frame at DIV=4: 40 cycles, 4 per bit, then idle.
    wr(4'h8, 32'd4);
    wr(4'h0, 32'h55);
    check("tx55_before", {31'd0, tx}, 32'd1);
    for (int i = 0; i < 40; i++) begin
      step();
      check($sformatf("tx55_c%0d", i), {31'd0, tx}, {31'd0, fbit(8'h55, i / 4)});
    end
    step();
    check("tx55_idle", {31'd0, tx}, 32'd1);
    rd_check("tx55_status", 4'h4, 32'h0000_0002);

    // IRQ: set while idle/empty, cleared during frame, back one cycle after stop.
    wr(4'hC, 32'd1);
    step();
    check("irq_idle", {31'd0, irq}, 32'd1);
    wr(4'h8, 32'd2);
    wr(4'h0, 32'hA3);
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("txa3_c%0d", i), {31'd0, tx}, {31'd0, fbit(8'hA3, i / 2)});
      check($sformatf("irq_frame_c%0d", i), {31'd0, irq}, 32'd0);
    end
    step();
    check("irq_stop_end", {31'd0, irq}, 32'd0);
    step();
    check("irq_after", {31'd0, irq}, 32'd1);
    wr(4'h0, 32'h5A);
    step();
    check("irq_new_data", {31'd0, irq}, 32'd0);
    repeat (25) step();
    wr(4'hC, 32'd0);
    step();

    // DIV change mid-bit: start bit keeps 8 cycles, later bits use 3.
    wr(4'h8, 32'd8);
    wr(4'h0, 32'hFF);
    a = cycle;
    wr(4'h8, 32'd3);
    wr(4'h0, 32'h00);
    wait_tx(1'b1, 100, "divchg_rise_timeout");
    check("divchg_start_len", 32'(cycle - a), 32'd9);
    wait_tx(1'b0, 100, "divchg_next_timeout");
    check("divchg_frame_len", 32'(cycle - a), 32'd36);
    repeat (40) step();

    // Overflow: long first frame stalls the FIFO while 17 bytes arrive.
    wr(4'h8, 32'd100);
    wr(4'h0, 32'h00);
    for (int i = 0; i < 17; i++) wr(4'h0, {24'd0, ovf_bytes[i]});
    rd_check("ovf_status_full", 4'h4, 32'h0000_100D);
    wr(4'h8, 32'd2);
    wait_tx(1'b1, 300, "ovf_stall_timeout");
    nfr = 0;
    done = 1'b0;
    for (int f = 0; f < 20 && !done; f++) begin
      found = 1'b0;
      for (int k = 0; k < 40; k++) begin
        step();
        if (tx == 1'b0) begin
          found = 1'b1;
          break;
        end
      end
      if (!found) begin
        done = 1'b1;
      end else begin
        rx = 8'd0;
        repeat (3) step();
        rx[0] = tx;
        for (int b = 1; b < 8; b++) begin
          repeat (2) step();
          rx[b] = tx;
        end
        repeat (2) step();
        check($sformatf("ovf_stop%0d", nfr), {31'd0, tx}, 32'd1);
        if (nfr < 16) check($sformatf("ovf_byte%0d", nfr), {24'd0, rx}, {24'd0, ovf_bytes[nfr]});
        nfr++;
      end
    end
    check("ovf_frames", 32'(nfr), 32'd16);
    rd_check("ovf_status_sticky", 4'h4, 32'h0000_000A);
    wr(4'h4, 32'h8);
    rd_check("ovf_status_clr", 4'h4, 32'h0000_0002);

    // Reset during data bit 3 with a second byte queued.
    wr(4'h8, 32'd4);
    wr(4'h0, 32'h00);
    wr(4'h0, 32'h00);
    repeat (16) step();
    check("rstmid_bit3_low", {31'd0, tx}, 32'd0);
    wb_rst = 1'b1;
    step();
    check("rstmid_tx", {31'd0, tx}, 32'd1);
    wb_rst = 1'b0;
    rd_check("rstmid_status", 4'h4, 32'h0000_0002);
    rd_check("rstmid_div", 4'h8, 32'd434);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (tx == 1'b0) lows++;
    end
    check("rstmid_no_frames", 32'(lows), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
